burst_memory: RTL and testbench

BURST_MEMORY -- requirements
Module: burst_memory

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_array.sv | 38 +++
 rtl/burst_memory.sv | 129 ++++++++++++
 tb/tb_burst_memory.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared burst-size encodings, beat lookup and FSM state codes
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_1  = 2'b00,
        SIZE_4  = 2'b01,
        SIZE_8  = 2'b10,
        SIZE_16 = 2'b11
    } access_size_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    function automatic logic [4:0] beats_of(input logic [1:0] size);
        logic [4:0] n;
        case (size)
            SIZE_1:  n = 5'd1;
            SIZE_4:  n = 5'd4;
            SIZE_8:  n = 5'd8;
            default: n = 5'd16;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - word-wide byte-lane RAM, synchronous read, lane 0 is the MSB byte
module mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 262144,
    parameter int WORD_W     = 18
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [WORD_W-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Byte lane i holds the byte at word offset i, so the lowest address sits in the MSBs.
    always_ff @(posedge clock) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    mem[addr][DATA_WIDTH-1-8*i -: 8] <= wdata[DATA_WIDTH-1-8*i -: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (en && (we == '0)) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/burst_memory.sv
// rtl/burst_memory.sv - burst read/write controller over a byte-addressed big-endian RAM
module burst_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1048576
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [1:0]            access_size,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  error
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(DEPTH);
    localparam int WORDS  = DEPTH / BYTES;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [1:0]       state;
    logic [4:0]       beat;
    logic [4:0]       count;
    logic [OFF_W-1:0] base;

    logic             accept;
    logic             aligned;
    logic [4:0]       req_beats;
    logic             issue_read;
    logic             write_now;
    logic [OFF_W-1:0] byte_addr;
    logic [WORD_W-1:0] word_addr;

    assign busy      = (state != ST_IDLE);
    assign accept    = reset_n && enable && !busy;
    assign aligned   = ((address % ADDR_WIDTH'(BYTES)) == '0);
    assign req_beats = beats_of(access_size);

    // Beat 0 is issued straight from the request inputs so reads return in T+1
    // and writes take data_in in the acceptance cycle.
    always_comb begin
        issue_read = 1'b0;
        write_now  = 1'b0;
        byte_addr  = address[OFF_W-1:0];
        if (state == ST_IDLE) begin
            if (accept && aligned) begin
                issue_read = !rw;
                write_now  = rw;
            end
        end else begin
            byte_addr = base + OFF_W'(beat) * OFF_W'(BYTES);
            if (state == ST_READ) begin
                issue_read = (beat < count);
            end else begin
                write_now = 1'b1;
            end
        end
        if (!reset_n) begin
            issue_read = 1'b0;
            write_now  = 1'b0;
        end
    end

    assign word_addr = WORD_W'(byte_addr / OFF_W'(BYTES));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            beat       <= '0;
            count      <= '0;
            base       <= '0;
            data_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            error      <= accept && !aligned;
            data_valid <= issue_read;
            case (state)
                ST_IDLE: begin
                    if (accept && aligned) begin
                        base  <= address[OFF_W-1:0];
                        count <= req_beats;
                        beat  <= 5'd1;
                        if (!rw) begin
                            state <= ST_READ;
                        end else if (req_beats != 5'd1) begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    // The final cycle only drains the last returned beat.
                    if (beat == count) begin
                        state <= ST_IDLE;
                    end else begin
                        beat <= beat + 5'd1;
                    end
                end
                ST_WRITE: begin
                    if (beat == count - 5'd1) begin
                        state <= ST_IDLE;
                    end else begin
                        beat <= beat + 5'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .WORDS     (WORDS),
        .WORD_W    (WORD_W)
    ) u_mem_array (
        .clock  (clock),
        .reset_n(reset_n),
        .en     (issue_read || write_now),
        .we     ({BYTES{write_now}}),
        .addr   (word_addr),
        .wdata  (data_in),
        .rdata  (data_out)
    );

endmodule

// File: tb/tb_burst_memory.sv
// tb/tb_burst_memory.sv - directed self-checking bench for burst_memory
module tb_burst_memory;
    localparam int DEPTH = 1048576;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        rw;
    logic [31:0] address;
    logic [1:0]  access_size;
    logic [31:0] data_in;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;
    logic        error;

    int checks = 0;
    int errors = 0;
    int pulse_at = 0;
    int busy_cnt;
    logic [31:0] exp_q [16];

    burst_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .rw         (rw),
        .address    (address),
        .access_size(access_size),
        .data_in    (data_in),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .error      (error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr1(input logic [31:0] addr, input logic [31:0] data);
        enable = 1'b1; rw = 1'b1; address = addr; access_size = 2'b00; data_in = data;
        tick();
        enable = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] addr, input logic [1:0] size, input int n,
                            input logic [31:0] base);
        enable = 1'b1; rw = 1'b1; address = addr; access_size = size; data_in = base;
        busy_cnt = 0;
        for (int k = 1; k < n; k++) begin
            tick();
            enable = 1'b0; address = 32'h0000_0F00; access_size = 2'b00; rw = 1'b0;
            data_in = base + k;
            if (busy) busy_cnt++;
        end
        tick();
    endtask

    // Checks beats 0..n-1 in cycles T+1..T+n, then two idle cycles.
    task automatic read_burst(input string tag, input logic [31:0] addr, input logic [1:0] size,
                              input int n);
        enable = 1'b1; rw = 1'b0; address = addr; access_size = size;
        for (int j = 1; j <= n + 2; j++) begin
            tick();
            enable = 1'b0; address = 32'h0000_0F00; access_size = 2'b00; rw = 1'b1;
            if (j == pulse_at) begin
                enable = 1'b1; rw = 1'b0; address = 32'h0000_0100;
            end
            chk({tag, "_valid"}, data_valid, (j <= n));
            chk({tag, "_busy"}, busy, (j <= n));
            if (j <= n) chk({tag, "_data"}, data_out, exp_q[j-1]);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; rw = 1'b0; address = 32'h100;
        access_size = 2'b00; data_in = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_data", data_out, 0);
        enable = 1'b0;
        reset_n = 1'b1;
        tick();

        // single write then read with big-endian byte check
        wr1(32'h100, 32'hDEADBEEF);
        chk("s1_wr_busy", busy, 0);
        enable = 1'b1; rw = 1'b0; address = 32'h100; access_size = 2'b00;
        tick();
        enable = 1'b0;
        chk("s1_valid", data_valid, 1);
        chk("s1_data", data_out, 32'hDEADBEEF);
        chk("s1_byte100", data_out[31:24], 8'hDE);
        tick();
        chk("s1_valid_off", data_valid, 0);
        chk("s1_hold", data_out, 32'hDEADBEEF);
        chk("s1_idle", busy, 0);

        // 16-beat write then 16-beat read
        wr_burst(32'h200, 2'b11, 16, 32'd0);
        chk("s2_wr_busy_cycles", busy_cnt, 15);
        chk("s2_wr_done", busy, 0);
        for (int k = 0; k < 16; k++) exp_q[k] = k;
        read_burst("s2_rd", 32'h200, 2'b11, 16);

        // wrap-around read across the top of storage
        wr1(DEPTH - 8, 32'hA0A0_0001);
        wr1(DEPTH - 4, 32'hA0A0_0002);
        wr1(32'h0, 32'hA0A0_0003);
        wr1(32'h4, 32'hA0A0_0004);
        exp_q[0] = 32'hA0A0_0001; exp_q[1] = 32'hA0A0_0002;
        exp_q[2] = 32'hA0A0_0003; exp_q[3] = 32'hA0A0_0004;
        read_burst("s3_wrap", DEPTH - 8, 2'b01, 4);
        exp_q[0] = 32'hA0A0_0004;
        read_burst("s3_hibits", 32'h8000_0004, 2'b00, 1);

        // misaligned request
        enable = 1'b1; rw = 1'b1; address = 32'h102; access_size = 2'b00; data_in = 32'h1111_1111;
        tick();
        enable = 1'b0;
        chk("s4_error", error, 1);
        chk("s4_busy", busy, 0);
        tick();
        chk("s4_error_pulse", error, 0);
        exp_q[0] = 32'hDEADBEEF;
        read_burst("s4_rd100", 32'h100, 2'b00, 1);

        // enable pulsed mid-burst is ignored
        for (int k = 0; k < 8; k++) exp_q[k] = k;
        pulse_at = 3;
        read_burst("s5_rd", 32'h200, 2'b10, 8);
        pulse_at = 0;

        // reset during an 8-beat write
        wr_burst(32'h300, 2'b10, 8, 32'h1000);
        for (int k = 0; k < 8; k++) exp_q[k] = 32'h1000 + k;
        read_burst("s6_pre", 32'h300, 2'b10, 8);
        enable = 1'b1; rw = 1'b1; address = 32'h300; access_size = 2'b10; data_in = 32'h2000;
        for (int k = 1; k <= 3; k++) begin
            tick();
            enable = 1'b0;
            data_in = 32'h2000 + k;
        end
        reset_n = 1'b0;
        tick();
        chk("s6_busy", busy, 0);
        chk("s6_valid", data_valid, 0);
        chk("s6_error", error, 0);
        chk("s6_data", data_out, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_q[k] = 32'h2000 + k;
        read_burst("s6_post", 32'h300, 2'b10, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
